// File: rtl/wb_trace_display.sv
// Captures write-back {pc,data} samples into a small FIFO and replays each on the 7-seg display for HOLD_CYCLES.
// Latency: push visible in Count after 1 edge, shown 1 edge later if idle; no backpressure, full drops set sticky Overflow.
module wb_trace_display #(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 100000000,
  parameter int SCAN_CYCLES = 100000
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [31:0]            PCResultO,
  input  logic [31:0]            writeData,
  input  logic                   Capture,
  input  logic                   Sel,
  output logic [6:0]             out7,
  output logic [7:0]             en_out,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int PW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [31:0]   lastPc;
  logic          lastPcVld;
  logic [0:0]    state;
  logic [HW-1:0] dwellCnt;
  logic [63:0]   shown;
  logic [2:0]    idx;
  logic [PW-1:0] prescale;
  logic          pushReq;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [31:0]   word;
  logic [3:0]    nibble;

  assign empty   = (Count == '0);
  assign full    = (Count == (AW+1)'(DEPTH));
  assign pushReq = Capture && (!lastPcVld || (PCResultO != lastPc));
  // The only pop is the dwell FSM loading the head entry.
  assign pop     = !empty && ((state == IDLE) || (dwellCnt == '0));
  assign push    = pushReq && (!full || pop);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      Count     <= '0;
      Overflow  <= 1'b0;
      lastPc    <= '0;
      lastPcVld <= 1'b0;
    end else begin
      if (push) begin
        wrPtr     <= wrPtr + 1'b1;
        lastPc    <= PCResultO;
        lastPcVld <= 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (pushReq && !push) begin
        Overflow <= 1'b1;
      end
      case ({push, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: Count <= Count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wrPtr] <= {PCResultO, writeData};
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      dwellCnt <= '0;
      shown    <= '0;
    end else if (pop) begin
      shown    <= mem[rdPtr];
      dwellCnt <= HW'(HOLD_CYCLES - 1);
      state    <= SHOW;
    end else if (state == SHOW) begin
      if (dwellCnt == '0) begin
        state <= IDLE;
      end else begin
        dwellCnt <= dwellCnt - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      idx      <= '0;
      prescale <= '0;
    end else if (prescale == PW'(SCAN_CYCLES - 1)) begin
      prescale <= '0;
      idx      <= idx + 1'b1;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign word   = Sel ? shown[63:32] : shown[31:0];
  assign nibble = word[{idx, 2'b00} +: 4];
  assign en_out = ~(8'b1 << idx);

  always_comb begin
    out7 = 7'h7F;
    case (nibble)
      4'h0: out7 = 7'h40;
      4'h1: out7 = 7'h79;
      4'h2: out7 = 7'h24;
      4'h3: out7 = 7'h30;
      4'h4: out7 = 7'h19;
      4'h5: out7 = 7'h12;
      4'h6: out7 = 7'h02;
      4'h7: out7 = 7'h78;
      4'h8: out7 = 7'h00;
      4'h9: out7 = 7'h10;
      4'hA: out7 = 7'h08;
      4'hB: out7 = 7'h03;
      4'hC: out7 = 7'h46;
      4'hD: out7 = 7'h21;
      4'hE: out7 = 7'h06;
      4'hF: out7 = 7'h0E;
      default: out7 = 7'h7F;
    endcase
  end

endmodule
